// File: rtl/burst_serializer_mono8.sv
// ============================================================================
// Module   : burst_serializer_mono8
// Brief    : Unpacks PIXELS_PER_BURST-wide Mono8 words into one pixel per beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_serializer_mono8 #(
    parameter int IN_ROWS          = 20,
    parameter int IN_COLS          = 20,
    parameter int PIXELS_PER_BURST = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    output logic                          ap_idle,
    output logic                          ap_ready,
    output logic                          ap_done,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [8*PIXELS_PER_BURST-1:0] s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [7:0]                    m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [$clog2(IN_COLS)-1:0]    cnt_col,
    output logic [$clog2(IN_ROWS)-1:0]    cnt_row
);

    localparam int c_COL_W  = $clog2(IN_COLS);
    localparam int c_ROW_W  = $clog2(IN_ROWS);
    localparam int c_IDX_W  = (PIXELS_PER_BURST > 1) ? $clog2(PIXELS_PER_BURST) : 1;
    localparam int c_WORDS  = IN_ROWS * IN_COLS / PIXELS_PER_BURST;
    localparam int c_WCNT_W = $clog2(c_WORDS + 1);

    localparam logic [c_COL_W-1:0]  c_COL_LAST = c_COL_W'(IN_COLS - 1);
    localparam logic [c_ROW_W-1:0]  c_ROW_LAST = c_ROW_W'(IN_ROWS - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(PIXELS_PER_BURST - 1);
    localparam logic [c_WCNT_W-1:0] c_WORDS_L  = c_WCNT_W'(c_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    logic [8*PIXELS_PER_BURST-1:0] r_buf;
    logic [c_IDX_W-1:0]          r_idx;
    logic                        r_buf_valid;
    logic [c_WCNT_W-1:0]         r_wcnt;
    logic [c_COL_W-1:0]          r_col;
    logic [c_ROW_W-1:0]          r_row;

    logic       w_in_hs;
    logic       w_out_hs;
    logic       w_last_byte;
    logic       w_words_left;
    logic       w_col_last;
    logic       w_tlast;
    logic [7:0] w_bytes [PIXELS_PER_BURST];

    for (genvar g = 0; g < PIXELS_PER_BURST; g++) begin : g_bytes
        assign w_bytes[g] = r_buf[8*g +: 8];
    end

    assign w_last_byte  = (r_idx == c_IDX_LAST);
    assign w_words_left = (r_wcnt < c_WORDS_L);
    assign w_col_last   = (r_col == c_COL_LAST);
    assign w_tlast      = r_buf_valid && w_col_last && (r_row == c_ROW_LAST);

    // Refill is allowed in the same cycle the final byte leaves, keeping 1 pixel/cycle.
    assign s_axis_tready = (r_state == S_RUN) && w_words_left &&
                           (!r_buf_valid || (w_last_byte && m_axis_tready && m_axis_tvalid));

    assign w_in_hs  = s_axis_tvalid && s_axis_tready;
    assign w_out_hs = m_axis_tvalid && m_axis_tready;

    assign ap_idle       = (r_state == S_IDLE);
    assign ap_ready      = (r_state == S_IDLE) || (r_state == S_DONE);
    assign ap_done       = (r_state == S_DONE);
    assign m_axis_tvalid = r_buf_valid;
    assign m_axis_tdata  = w_bytes[r_idx];
    assign m_axis_tlast  = w_tlast;
    assign cnt_col       = r_col;
    assign cnt_row       = r_row;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_idx       <= '0;
            r_buf_valid <= 1'b0;
            r_wcnt      <= '0;
            r_col       <= '0;
            r_row       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_state     <= S_RUN;
                        r_idx       <= '0;
                        r_buf_valid <= 1'b0;
                        r_wcnt      <= '0;
                        r_col       <= '0;
                        r_row       <= '0;
                    end
                end
                S_RUN: begin
                    // A new word overrides the wrap of the byte index.
                    if (w_in_hs) begin
                        r_buf       <= s_axis_tdata;
                        r_idx       <= '0;
                        r_buf_valid <= 1'b1;
                        r_wcnt      <= r_wcnt + c_WCNT_W'(1);
                    end else if (w_out_hs) begin
                        if (w_last_byte) begin
                            r_idx       <= '0;
                            r_buf_valid <= 1'b0;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                    if (w_out_hs) begin
                        if (w_tlast) begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_state <= S_DONE;
                        end else if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + c_ROW_W'(1);
                        end else begin
                            r_col <= r_col + c_COL_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/burst_serializer_mono8.md
BURST_SERIALIZER_MONO8 -- requirements
Module: burst_serializer_mono8

Interface
REQ-001 Parameter IN_ROWS, default 20: frame height in pixels.
REQ-002 Parameter IN_COLS, default 20: frame width in pixels; SHALL be a multiple of PIXELS_PER_BURST.
REQ-003 Parameter PIXELS_PER_BURST, default 4: Mono8 pixels packed per input word.
REQ-004 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 ap_start  in  1  start one frame.
REQ-007 ap_idle, ap_ready, ap_done  out  1 each  block-level control status.
REQ-008 s_axis_tvalid  in  1 / s_axis_tready  out  1 / s_axis_tdata  in  8*PIXELS_PER_BURST  packed burst word from the frame grabber.
REQ-009 m_axis_tvalid  out  1 / m_axis_tready  in  1 / m_axis_tdata  out  8  one Mono8 pixel per beat.
REQ-010 m_axis_tlast  out  1  high on the final pixel of the frame.
REQ-011 cnt_col  out  $clog2(IN_COLS) / cnt_row  out  $clog2(IN_ROWS)  coordinates of the pixel currently on m_axis_tdata.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
REQ-013 IDLE: ap_idle=1, ap_ready=1, s_axis_tready=0, m_axis_tvalid=0; ap_start=1 -> RUN next cycle, with counters at 0.
REQ-014 RUN: ap_idle=0, ap_ready=0; accept exactly IN_ROWS*IN_COLS/PIXELS_PER_BURST input words, then stop accepting.
REQ-015 Internal buffer: one word register, a byte index 0..PIXELS_PER_BURST-1 and a buf_valid flag.
REQ-016 s_axis_tready=1 only in RUN, while words remain, and when (!buf_valid) or (index==PIXELS_PER_BURST-1 and m_axis_tready and m_axis_tvalid).
REQ-017 The buffer SHALL reload in the same cycle its last byte is consumed: no bubble, sustained 1 pixel/cycle.
REQ-018 Input word handshake loads the buffer: buf_valid=1, index=0, m_axis_tvalid=1 on the next cycle (latency 1 cycle).
REQ-019 m_axis_tdata = buffer byte[index]; byte 0 = bits [7:0] SHALL be emitted first (LSB-first).
REQ-020 m_axis_tvalid = buf_valid; data, tlast and counters SHALL hold stable while tvalid=1 and tready=0.
REQ-021 Per output handshake: index++ (wrap to 0 clears buf_valid unless reloaded); cnt_col++; at cnt_col==IN_COLS-1, cnt_col wraps to 0 and cnt_row++.
REQ-022 m_axis_tlast=1 iff tvalid and cnt_row==IN_ROWS-1 and cnt_col==IN_COLS-1.
REQ-023 Handshake with tlast=1 -> DONE; cnt_col and cnt_row return to 0.
REQ-024 DONE lasts exactly one cycle: ap_done=1, ap_ready=1, s_axis_tready=0, m_axis_tvalid=0; then -> IDLE.
REQ-025 ap_start while in RUN or DONE SHALL be ignored; a frame starts only from IDLE.
REQ-026 s_axis_tvalid in IDLE/DONE SHALL not be consumed (tready=0); words wait upstream.
REQ-027 Simultaneous input handshake and consumption of the last buffered byte: the new word wins, buf_valid stays 1, index=0.
REQ-028 Word counter width SHALL be $clog2(IN_ROWS*IN_COLS/PIXELS_PER_BURST+1); there is no overflow past frame end.

Reset
REQ-029 With reset=0, asynchronously: state=IDLE, buf_valid=0, index=0, word count=0, cnt_col=0, cnt_row=0.
REQ-030 Outputs under reset: ap_idle=1, ap_ready=1, ap_done=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
REQ-031 Reset during RUN SHALL discard the buffered word and partial frame; the next ap_start begins a fresh frame at (0,0).

Verification (IN_ROWS=4, IN_COLS=8, PIXELS_PER_BURST=4)
REQ-032 Full rate, ap_start pulse, 8 words 0x03020100, 0x07060504, ..., tready=1 -> pixels 0x00..0x1F on consecutive cycles; first pixel 1 cycle after the first word; tlast on 0x1F at (row 3, col 7); ap_done a single cycle later.
REQ-033 m_axis_tready toggled 1/0 every cycle -> identical 32-pixel sequence; tdata, cnt_col, cnt_row stable during stalls; s_axis_tready only on a last-byte handshake.
REQ-034 s_axis_tvalid with random gaps -> no duplicated or dropped pixel; m_axis_tvalid=0 while the buffer is empty.
REQ-035 Reset=0 after 13 pixels (row 1, col 5) -> all outputs at reset values immediately; a new frame restarts at pixel (0,0) with the first word's byte 0.
REQ-036 ap_start held high continuously for 3 frames -> each frame is 32 pixels, 1-cycle DONE, 1 IDLE cycle, then the next RUN; a 9th word presented early is not accepted until the next RUN.
